mantissa_normalizer_pipe: RTL

MANTISSA_NORMALIZER_PIPE -- requirements
Module: mantissa_normalizer_pipe

---
 rtl/mantissa_normalizer_pipe.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mantissa_normalizer_pipe.sv
// Two-stage mantissa normaliser: S1 registers operands and leading-zero count, S2 registers the result.
// Optional feature: define MANT_NORM_SUBNORMAL_EN to produce subnormal results on underflow instead of flushing to zero.
`timescale 1ns/1ps

module mantissa_normalizer_pipe #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] in_mant,
    input  logic              in_carry,
    input  logic [EXP_W-1:0]  in_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-2:0] out_mant,
    output logic [EXP_W-1:0]  out_exp,
    output logic [EXP_W-1:0]  out_shift,
    output logic              out_zero,
    output logic              out_underflow,
    output logic              out_overflow
);

    localparam int LZ_W = $clog2(MANT_W + 1);
    // One extra bit so exponent arithmetic can be range-checked before it could wrap.
    localparam int CW   = ((LZ_W > EXP_W) ? LZ_W : EXP_W) + 1;
    localparam logic [CW-1:0] EXP_MAX = CW'({EXP_W{1'b1}});

    logic              ready_q;
    logic              s1_valid;
    logic [MANT_W-1:0] s1_mant;
    logic              s1_carry;
    logic [EXP_W-1:0]  s1_exp;
    logic [LZ_W-1:0]   s1_lz;
    logic [LZ_W-1:0]   lz_c;
    logic              s1_adv;
    logic              s2_adv;

    logic [MANT_W-2:0] n_mant;
    logic [EXP_W-1:0]  n_exp;
    logic [EXP_W-1:0]  n_shift;
    logic              n_zero;
    logic              n_uf;
    logic              n_of;
    logic [CW-1:0]     sum;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = ready_q && s1_adv;

    // Leading-zero count; the highest set bit is visited last and wins.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        lz_c = LZ_W'(MANT_W);
        for (int i = 0; i < MANT_W; i++) begin
            if (in_mant[i]) lz_c = LZ_W'(MANT_W - 1 - i);
        end
    end

    // Held low through reset and until the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
        if (!rst_n) ready_q <= 1'b0;
        else        ready_q <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_mant  <= '0;
            s1_carry <= 1'b0;
            s1_exp   <= '0;
            s1_lz    <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid && in_ready;
            if (in_valid && in_ready) begin
                s1_mant  <= in_mant;
                s1_carry <= in_carry;
                s1_exp   <= in_exp;
                s1_lz    <= lz_c;
            end
        end
    end

    always_comb begin
        n_mant  = '0;
        n_exp   = '0;
        n_shift = '0;
        n_zero  = 1'b0;
        n_uf    = 1'b0;
        n_of    = 1'b0;
        sum     = '0;
        if (s1_carry) begin
            sum    = CW'(s1_exp) + CW'(1);
            n_mant = s1_mant[MANT_W-1:1];
            n_exp  = sum[EXP_W-1:0];
        end else if (s1_mant == '0) begin
            n_zero = 1'b1;
        end else if (CW'(s1_lz) < CW'(s1_exp)) begin
            sum     = CW'(s1_exp) - CW'(s1_lz);
            n_mant  = (MANT_W-1)'(s1_mant << s1_lz);
            n_exp   = sum[EXP_W-1:0];
            n_shift = EXP_W'(s1_lz);
        end else begin
            n_uf = 1'b1;
`ifdef MANT_NORM_SUBNORMAL_EN
            // Shift stops one short of the exponent so the result lands at exponent 0.
            n_shift = (s1_exp == '0) ? '0 : s1_exp - EXP_W'(1);
            n_mant  = (MANT_W-1)'(s1_mant << n_shift);
            n_zero  = (n_mant == '0);
`else
            n_zero  = 1'b1;
`endif
        end
        if (sum >= EXP_MAX) begin
            n_of   = 1'b1;
            n_exp  = '1;
            n_mant = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_mant      <= '0;
            out_exp       <= '0;
            out_shift     <= '0;
            out_zero      <= 1'b0;
            out_underflow <= 1'b0;
            out_overflow  <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_mant      <= n_mant;
                out_exp       <= n_exp;
                out_shift     <= n_shift;
                out_zero      <= n_zero;
                out_underflow <= n_uf;
                out_overflow  <= n_of;
            end
        end
    end

endmodule
